// File: rtl/instr_mem_pipe_if.sv
// Fetch, response and program-load signals of the pipelined instruction memory.
// A fetch transfers on a rising edge where req_valid && req_ready. Responses carry no back-pressure.
interface instr_mem_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_instr;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output req_valid, req_addr, flush, prog_we, prog_addr, prog_data,
        input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, prog_we, prog_addr, prog_data,
        output req_ready, resp_valid, resp_instr, resp_addr, resp_err
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// Byte-addressed big-endian instruction memory with a LATENCY-deep registered fetch
// pipeline, flush for branch redirects, fault reporting and a word-wide program port.
module instr_mem_pipe #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 64,
    parameter int LATENCY     = 1
) (
    input  logic             clk,
    input  logic             rst,
    instr_mem_pipe_if.slave  bus
);
    localparam int NB     = DATA_W / 8;
    localparam int MEM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W-1:0] NB_A      = ADDR_W'(NB);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - NB);

    logic [7:0] mem [DEPTH_BYTES];

    logic              accept;
    logic              fetch_fault;
    logic              prog_fault;
    logic [ADDR_W-1:0] prog_base;
    logic [MEM_AW-1:0] fetch_idx;
    logic [MEM_AW-1:0] prog_idx;
    logic [DATA_W-1:0] rd_word;

    logic [LATENCY-1:0] stage_valid;
    logic [LATENCY-1:0] stage_err;
    logic [ADDR_W-1:0]  stage_addr  [LATENCY];
    logic [DATA_W-1:0]  stage_instr [LATENCY];

    // Program writes win the cycle, so a fetch never races a write at the same edge.
    assign bus.req_ready = !rst && !bus.prog_we;
    assign accept        = bus.req_valid && bus.req_ready;

    assign fetch_fault = ((bus.req_addr % NB_A) != '0) || (bus.req_addr > LAST_WORD);
    assign prog_base   = bus.prog_addr - (bus.prog_addr % NB_A);
    assign prog_fault  = prog_base > LAST_WORD;
    assign fetch_idx   = bus.req_addr[MEM_AW-1:0];
    assign prog_idx    = prog_base[MEM_AW-1:0];

    // Faulting fetches never touch the array and return an all-zero NOP.
    always_comb begin
        rd_word = '0;
        if (!fetch_fault) begin
            for (int b = 0; b < NB; b++) begin
                rd_word[DATA_W-1-8*b -: 8] = mem[fetch_idx + MEM_AW'(b)];
            end
        end
    end

    // Memory is not reset; loading during reset is allowed.
    always_ff @(posedge clk) begin
        if (bus.prog_we && !prog_fault) begin
            for (int b = 0; b < NB; b++) begin
                mem[prog_idx + MEM_AW'(b)] <= bus.prog_data[DATA_W-1-8*b -: 8];
            end
        end
    end

    // Payload moves only with a live valid, so the last stage holds the previous response when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            stage_err   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_addr[i]  <= '0;
                stage_instr[i] <= '0;
            end
        end else begin
            stage_valid[0] <= accept;
            if (accept) begin
                stage_addr[0]  <= bus.req_addr;
                stage_instr[0] <= rd_word;
                stage_err[0]   <= fetch_fault;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1] && !bus.flush;
                if (stage_valid[i-1] && !bus.flush) begin
                    stage_addr[i]  <= stage_addr[i-1];
                    stage_instr[i] <= stage_instr[i-1];
                    stage_err[i]   <= stage_err[i-1];
                end
            end
        end
    end

    assign bus.resp_valid = stage_valid[LATENCY-1];
    assign bus.resp_instr = stage_instr[LATENCY-1];
    assign bus.resp_addr  = stage_addr[LATENCY-1];
    assign bus.resp_err   = stage_err[LATENCY-1];
endmodule
